// File: rtl/box_eat_ctrl.sv
// box_eat_ctrl: places food from a random box generator and detects the snake eating it
// Ports: I_clk/I_rst clock and sync reset; I_start starts a game; I_step marks a head move;
//        I_head_x/y head position; I_box_x/y generator candidate; O_load/O_drive generator strobes;
//        O_food_x/y/O_food_valid placed food; O_eat eat pulse; O_score food count; O_fault placement failure.
module box_eat_ctrl #(
    parameter logic [9:0] X_MAX = 10'd630,
    parameter logic [9:0] Y_MAX = 10'd470,
    parameter int SETTLE = 2,
    parameter int MAX_RETRY = 7
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_start,
    input  logic       I_step,
    input  logic [9:0] I_head_x,
    input  logic [9:0] I_head_y,
    input  logic [9:0] I_box_x,
    input  logic [9:0] I_box_y,
    output logic       O_load,
    output logic       O_drive,
    output logic [9:0] O_food_x,
    output logic [9:0] O_food_y,
    output logic       O_food_valid,
    output logic       O_eat,
    output logic [7:0] O_score,
    output logic       O_fault
);
    typedef enum logic [2:0] {IDLE, SEED, REQ, WAIT, CHECK, ARMED} state_t;
    localparam logic [3:0] SETTLE_W = 4'(SETTLE);
    localparam logic [3:0] RETRY_W = 4'(MAX_RETRY);
    state_t state, state_n;
    logic [3:0] retry, retry_n, settle_cnt, settle_n;
    logic [9:0] food_x, food_x_n, food_y, food_y_n;
    logic food_valid, food_valid_n, eat, eat_n, fault, fault_n;
    logic [7:0] score, score_n;
    logic cand_ok, hit;
    assign cand_ok = I_box_x <= X_MAX && I_box_y <= Y_MAX && !(I_box_x == I_head_x && I_box_y == I_head_y);
    assign hit = I_step && I_head_x == food_x && I_head_y == food_y;
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= IDLE;
            retry <= '0;
            settle_cnt <= '0;
            food_x <= '0;
            food_y <= '0;
            food_valid <= 1'b0;
            eat <= 1'b0;
            fault <= 1'b0;
            score <= '0;
        end else begin
            state <= state_n;
            retry <= retry_n;
            settle_cnt <= settle_n;
            food_x <= food_x_n;
            food_y <= food_y_n;
            food_valid <= food_valid_n;
            eat <= eat_n;
            fault <= fault_n;
            score <= score_n;
        end
    end
    // The cycle after an eat is spent in REQ with the drive strobe held off,
    // so the generator is advanced one cycle after O_eat.
    always_comb begin
        state_n = state;
        retry_n = retry;
        settle_n = settle_cnt;
        food_x_n = food_x;
        food_y_n = food_y;
        food_valid_n = food_valid;
        eat_n = 1'b0;
        fault_n = fault;
        score_n = score;
        case (state)
            IDLE: if (I_start) begin
                score_n = '0;
                fault_n = 1'b0;
                food_valid_n = 1'b0;
                retry_n = '0;
                state_n = SEED;
            end
            SEED: state_n = REQ;
            REQ: if (!eat) begin
                retry_n = retry + 4'd1;
                settle_n = '0;
                state_n = WAIT;
            end
            WAIT: if (settle_cnt == SETTLE_W - 4'd1) state_n = CHECK;
                  else settle_n = settle_cnt + 4'd1;
            CHECK: if (cand_ok) begin
                food_x_n = I_box_x;
                food_y_n = I_box_y;
                food_valid_n = 1'b1;
                retry_n = '0;
                state_n = ARMED;
            end else if (retry < RETRY_W) begin
                state_n = REQ;
            end else begin
                fault_n = 1'b1;
                food_valid_n = 1'b0;
                state_n = IDLE;
            end
            ARMED: if (hit) begin
                eat_n = 1'b1;
                food_valid_n = 1'b0;
                score_n = score == 8'hff ? score : score + 8'd1;
                state_n = REQ;
            end
            default: state_n = IDLE;
        endcase
    end
    assign O_load = state == SEED;
    assign O_drive = state == REQ && !eat;
    assign O_food_x = food_x;
    assign O_food_y = food_y;
    assign O_food_valid = food_valid;
    assign O_eat = eat;
    assign O_score = score;
    assign O_fault = fault;
endmodule

// File: tb/tb_box_eat_ctrl.sv
// tb_box_eat_ctrl: randomized self-checking bench for box_eat_ctrl against a placement/eat model
module tb_box_eat_ctrl;
    logic I_clk = 0, I_rst = 0, I_start = 0, I_step = 0;
    logic [9:0] I_head_x = 0, I_head_y = 0, I_box_x = 0, I_box_y = 0;
    logic O_load, O_drive, O_food_valid, O_eat, O_fault;
    logic [9:0] O_food_x, O_food_y;
    logic [7:0] O_score;
    int n_checks = 0, n_fail = 0;
    logic [9:0] cx[16], cy[16];
    int n_cand;
    int drives;
    box_eat_ctrl dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_start(I_start), .I_step(I_step),
        .I_head_x(I_head_x), .I_head_y(I_head_y), .I_box_x(I_box_x), .I_box_y(I_box_y),
        .O_load(O_load), .O_drive(O_drive), .O_food_x(O_food_x), .O_food_y(O_food_y),
        .O_food_valid(O_food_valid), .O_eat(O_eat), .O_score(O_score), .O_fault(O_fault)
    );
    always #5 I_clk = ~I_clk;
    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask
    task automatic do_reset();
        I_rst = 1;
        I_start = 0;
        I_step = 0;
        tick();
        I_rst = 0;
    endtask
    function automatic bit model_ok(logic [9:0] x, logic [9:0] y, logic [9:0] hx, logic [9:0] hy);
        return x <= 10'd630 && y <= 10'd470 && !(x == hx && y == hy);
    endfunction
    // Serves candidates in order on each drive pulse until food is placed or a fault appears.
    task automatic run_placement(input bit do_start);
        int idx = 0;
        bit done = 0;
        drives = 0;
        if (n_cand > 0) begin
            I_box_x = cx[0];
            I_box_y = cy[0];
        end
        if (do_start) begin
            I_start = 1;
            tick();
            I_start = 0;
        end
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            if (O_drive) begin
                drives++;
                if (idx < n_cand) begin
                    I_box_x = cx[idx];
                    I_box_y = cy[idx];
                end
                idx++;
            end
            if (O_food_valid || O_fault) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL placement_timeout: got no valid/fault, need one within 300 cycles");
        end
    endtask
    task automatic test_reset();
        I_rst = 1;
        tick();
        tick();
        I_rst = 0;
        n_checks++;
        if ({O_load, O_drive, O_food_valid, O_eat, O_fault} !== 5'b0 || O_score !== 8'd0 || O_food_x !== 10'd0 || O_food_y !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got load=%b drive=%b valid=%b eat=%b fault=%b score=%0d food=(%0d,%0d), need all 0",
                     O_load, O_drive, O_food_valid, O_eat, O_fault, O_score, O_food_x, O_food_y);
        end
    endtask
    task automatic test_start_latency();
        logic [4:0] exp_load = 5'b00001, exp_drive = 5'b00010;
        I_head_x = 0; I_head_y = 0; I_box_x = 100; I_box_y = 200;
        I_start = 1;
        tick();
        I_start = 0;
        for (int c = 1; c <= 5; c++) begin
            n_checks++;
            if (O_load !== exp_load[c-1] || O_drive !== exp_drive[c-1] || O_food_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL start_cycle%0d: got load=%b drive=%b valid=%b, need load=%b drive=%b valid=0",
                         c, O_load, O_drive, O_food_valid, exp_load[c-1], exp_drive[c-1]);
            end
            if (c < 5) tick();
        end
        tick();
        n_checks++;
        if (O_food_valid !== 1'b1 || O_food_x !== 10'd100 || O_food_y !== 10'd200 || O_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL start_cycle6: got valid=%b food=(%0d,%0d) fault=%b, need valid=1 food=(100,200) fault=0",
                     O_food_valid, O_food_x, O_food_y, O_fault);
        end
    endtask
    task automatic test_step_ignored();
        I_head_x = 0; I_head_y = 0;
        I_step = 1;
        I_start = 1;
        tick();
        I_step = 0;
        I_start = 0;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (O_eat !== 1'b0 || O_load !== 1'b0 || O_drive !== 1'b0 || O_food_valid !== 1'b1 || O_score !== 8'd0 ||
                O_food_x !== 10'd100 || O_food_y !== 10'd200) begin
                n_fail++;
                $display("FAIL armed_hold%0d: got eat=%b load=%b drive=%b valid=%b score=%0d food=(%0d,%0d), need 0,0,0,1,0,(100,200)",
                         c, O_eat, O_load, O_drive, O_food_valid, O_score, O_food_x, O_food_y);
            end
            tick();
        end
    endtask
    task automatic test_eat();
        I_head_x = 100; I_head_y = 200;
        I_step = 1;
        tick();
        I_step = 0;
        I_head_x = 5; I_head_y = 5;
        n_checks++;
        if (O_eat !== 1'b1 || O_score !== 8'd1 || O_food_valid !== 1'b0 || O_drive !== 1'b0) begin
            n_fail++;
            $display("FAIL eat_pulse: got eat=%b score=%0d valid=%b drive=%b, need eat=1 score=1 valid=0 drive=0",
                     O_eat, O_score, O_food_valid, O_drive);
        end
        tick();
        n_checks++;
        if (O_eat !== 1'b0 || O_drive !== 1'b1) begin
            n_fail++;
            $display("FAIL eat_drive: got eat=%b drive=%b, need eat=0 drive=1", O_eat, O_drive);
        end
        n_cand = 1; cx[0] = 100; cy[0] = 200;
        run_placement(0);
        n_checks++;
        if (O_food_valid !== 1'b1 || O_food_x !== 10'd100 || O_food_y !== 10'd200 || O_score !== 8'd1) begin
            n_fail++;
            $display("FAIL eat_rearm: got valid=%b food=(%0d,%0d) score=%0d, need valid=1 food=(100,200) score=1",
                     O_food_valid, O_food_x, O_food_y, O_score);
        end
    endtask
    task automatic test_retry();
        do_reset();
        I_head_x = 0; I_head_y = 0;
        n_cand = 4;
        for (int i = 0; i < 3; i++) begin cx[i] = 700; cy[i] = 10; end
        cx[3] = 40; cy[3] = 40;
        run_placement(1);
        n_checks++;
        if (drives !== 4 || O_food_valid !== 1'b1 || O_food_x !== 10'd40 || O_food_y !== 10'd40 || O_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_then_ok: got drives=%0d valid=%b food=(%0d,%0d) fault=%b, need 4,1,(40,40),0",
                     drives, O_food_valid, O_food_x, O_food_y, O_fault);
        end
    endtask
    task automatic test_fault();
        do_reset();
        I_head_x = 7; I_head_y = 9;
        n_cand = 16;
        for (int i = 0; i < 16; i++) begin cx[i] = 7; cy[i] = 9; end
        run_placement(1);
        n_checks++;
        if (drives !== 7 || O_fault !== 1'b1 || O_food_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_fault: got drives=%0d fault=%b valid=%b, need 7,1,0", drives, O_fault, O_food_valid);
        end
        tick();
        tick();
        n_checks++;
        if (O_fault !== 1'b1 || O_drive !== 1'b0 || O_load !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_idle: got fault=%b drive=%b load=%b, need 1,0,0", O_fault, O_drive, O_load);
        end
        I_start = 1;
        tick();
        I_start = 0;
        n_checks++;
        if (O_fault !== 1'b0 || O_load !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_clear: got fault=%b load=%b, need 0,1", O_fault, O_load);
        end
    endtask
    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            logic [9:0] hx, hy, ex, ey;
            int exp_drives;
            bit exp_valid;
            do_reset();
            hx = 10'($urandom_range(0, 630));
            hy = 10'($urandom_range(0, 470));
            I_head_x = hx; I_head_y = hy;
            n_cand = 10;
            for (int i = 0; i < 10; i++) begin
                case ($urandom_range(0, 4))
                    0: begin cx[i] = 10'($urandom_range(631, 1023)); cy[i] = 10'($urandom_range(0, 1023)); end
                    1: begin cx[i] = 10'($urandom_range(0, 1023)); cy[i] = 10'($urandom_range(471, 1023)); end
                    2: begin cx[i] = hx; cy[i] = hy; end
                    default: begin cx[i] = 10'($urandom_range(0, 630)); cy[i] = 10'($urandom_range(0, 470)); end
                endcase
            end
            exp_drives = 7; exp_valid = 0; ex = 0; ey = 0;
            for (int i = 6; i >= 0; i--)
                if (model_ok(cx[i], cy[i], hx, hy)) begin
                    exp_drives = i + 1; exp_valid = 1; ex = cx[i]; ey = cy[i];
                end
            run_placement(1);
            n_checks++;
            if (drives !== exp_drives || O_food_valid !== exp_valid || O_fault !== !exp_valid ||
                (exp_valid && (O_food_x !== ex || O_food_y !== ey))) begin
                n_fail++;
                $display("FAIL random%0d: got drives=%0d valid=%b fault=%b food=(%0d,%0d), need %0d,%b,%b,(%0d,%0d)",
                         it, drives, O_food_valid, O_fault, O_food_x, O_food_y, exp_drives, exp_valid, !exp_valid, ex, ey);
            end
        end
    endtask
    task automatic test_saturate();
        int exp_score = 0;
        do_reset();
        I_head_x = 1; I_head_y = 1;
        n_cand = 1; cx[0] = 300; cy[0] = 300;
        run_placement(1);
        for (int e = 0; e < 256; e++) begin
            I_head_x = 300; I_head_y = 300;
            I_step = 1;
            tick();
            I_step = 0;
            I_head_x = 1; I_head_y = 1;
            exp_score = exp_score == 255 ? 255 : exp_score + 1;
            if (e >= 254) begin
                n_checks++;
                if (O_eat !== 1'b1 || O_score !== 8'(exp_score)) begin
                    n_fail++;
                    $display("FAIL saturate_eat%0d: got eat=%b score=%0d, need eat=1 score=%0d", e, O_eat, O_score, exp_score);
                end
            end
            run_placement(0);
        end
    endtask
    task automatic test_reset_wait();
        do_reset();
        I_head_x = 0; I_head_y = 0;
        n_cand = 1; cx[0] = 123; cy[0] = 45;
        run_placement(1);
        I_head_x = 123; I_head_y = 45;
        I_step = 1;
        tick();
        I_step = 0;
        I_head_x = 0; I_head_y = 0;
        tick();
        tick();
        I_rst = 1; I_start = 1; I_step = 1;
        tick();
        I_rst = 0; I_start = 0; I_step = 0;
        n_checks++;
        if ({O_load, O_drive, O_food_valid, O_eat, O_fault} !== 5'b0 || O_score !== 8'd0 || O_food_x !== 10'd0 || O_food_y !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_in_wait: got load=%b drive=%b valid=%b eat=%b fault=%b score=%0d food=(%0d,%0d), need all 0",
                     O_load, O_drive, O_food_valid, O_eat, O_fault, O_score, O_food_x, O_food_y);
        end
        tick();
        n_checks++;
        if (O_load !== 1'b0 || O_drive !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: got load=%b drive=%b, need 0,0", O_load, O_drive);
        end
    endtask
    initial begin
        test_reset();
        test_start_latency();
        test_step_ignored();
        test_eat();
        test_retry();
        test_fault();
        test_random();
        test_saturate();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
